cas_fsk_player: RTL and testbench

//  Parametrised cassette playback engine. Streams a tape image from a byte memory (on-chip SRAM or SDRAM port) and

---
 rtl/cas_fsk_player.sv | 222 ++++++++++++++++++++++
 tb/tb_cas_fsk_player.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_fsk_player.sv
// Cassette playback engine: streams a tape image from byte memory as CoCo FSK (bit 0 = 1200 Hz, bit 1 = 2400 Hz, LSB first).
// Define CAS_MONITOR_EN to enable the signed audio monitor output (audio_mon); otherwise audio_mon is tied to 0.
module cas_fsk_player #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned HALF_P0 = 23863,
  parameter int unsigned HALF_P1 = 11932,
  parameter int unsigned RD_LAT  = 1,
  parameter logic [15:0] MON_AMP = 16'h1000
) (
  input  logic              clk,
  input  logic              COCO_RESET_N,
  input  logic              en,
  input  logic              pause,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              data,
  output logic              playing,
  output logic              eot,
  output logic [15:0]       audio_mon
);

  localparam int unsigned      LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT   = LAT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] H0    = CNT_W'(HALF_P0 - 1);
  localparam logic [CNT_W-1:0] H1    = CNT_W'(HALF_P1 - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {P_START, P_HIGH, P_LOW} phase_t;

  state_t           state;
  phase_t           phase;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitcnt;
  logic [7:0]       sr;
  logic [7:0]       hold;
  logic             hold_valid;
  logic             rd_busy;
  logic [LAT_W-1:0] rd_cnt;
  logic             run;
  logic             fetch_ok;
  logic             rd_done;

  function automatic logic [CNT_W-1:0] half_m1(input logic b);
    return b ? H1 : H0;
  endfunction

  always_comb begin
    run      = en & ~pause;
    fetch_ok = mem_addr < tape_len;
    rd_done  = rd_busy && (rd_cnt == '0);
  end

  always_ff @(posedge clk or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      state      <= S_IDLE;
      phase      <= P_START;
      cnt        <= '0;
      bitcnt     <= '0;
      sr         <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      rd_busy    <= 1'b0;
      rd_cnt     <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      data       <= 1'b0;
      playing    <= 1'b0;
      eot        <= 1'b0;
    end else if (rewind) begin
      state      <= S_IDLE;
      phase      <= P_START;
      hold_valid <= 1'b0;
      rd_busy    <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      data       <= 1'b0;
      playing    <= 1'b0;
      eot        <= 1'b0;
    end else begin
      // Read engine: one read at a time; captures land in the holding reg unless WAIT consumes them directly.
      if (mem_rd) begin
        mem_rd   <= 1'b0;
        mem_addr <= mem_addr + 1'b1;
      end
      if (rd_busy) begin
        if (rd_done) begin
          rd_busy <= 1'b0;
          if (state != S_WAIT) begin
            hold       <= mem_data;
            hold_valid <= 1'b1;
          end
        end else begin
          rd_cnt <= rd_cnt - 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (run) begin
            if (fetch_ok) begin
              state   <= S_FETCH;
              mem_rd  <= 1'b1;
              rd_busy <= 1'b1;
              rd_cnt  <= LAT;
            end else begin
              state <= S_DONE;
              eot   <= 1'b1;
            end
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (rd_done) begin
            sr     <= mem_data;
            bitcnt <= '0;
            phase  <= P_START;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!run) begin
            data    <= 1'b0;
            playing <= 1'b0;
            phase   <= P_START;
          end else begin
            case (phase)
              P_START: begin
                data    <= 1'b1;
                playing <= 1'b1;
                cnt     <= half_m1(sr[0]);
                phase   <= P_HIGH;
                if (bitcnt == '0 && fetch_ok && !hold_valid && !rd_busy) begin
                  mem_rd  <= 1'b1;
                  rd_busy <= 1'b1;
                  rd_cnt  <= LAT;
                end
              end
              P_HIGH: begin
                if (cnt == '0) begin
                  data  <= 1'b0;
                  cnt   <= half_m1(sr[0]);
                  phase <= P_LOW;
                end else begin
                  cnt <= cnt - 1'b1;
                end
              end
              P_LOW: begin
                if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
                end else if (bitcnt != 3'd7) begin
                  sr     <= sr >> 1;
                  bitcnt <= bitcnt + 1'b1;
                  data   <= 1'b1;
                  cnt    <= half_m1(sr[1]);
                  phase  <= P_HIGH;
                end else if (hold_valid && mem_addr <= tape_len) begin
                  // Gapless hand-over: the held byte starts on the same edge the last low half ends.
                  sr         <= hold;
                  hold_valid <= 1'b0;
                  bitcnt     <= '0;
                  data       <= 1'b1;
                  cnt        <= half_m1(hold[0]);
                  phase      <= P_HIGH;
                  if (fetch_ok) begin
                    mem_rd  <= 1'b1;
                    rd_busy <= 1'b1;
                    rd_cnt  <= LAT;
                  end
                end else begin
                  data    <= 1'b0;
                  playing <= 1'b0;
                  phase   <= P_START;
                  if (hold_valid) begin
                    hold_valid <= 1'b0;
                    state      <= S_DONE;
                    eot        <= 1'b1;
                  end else if (rd_busy) begin
                    state <= S_WAIT;
                  end else if (fetch_ok) begin
                    state   <= S_FETCH;
                    mem_rd  <= 1'b1;
                    rd_busy <= 1'b1;
                    rd_cnt  <= LAT;
                  end else begin
                    state <= S_DONE;
                    eot   <= 1'b1;
                  end
                end
              end
              default: phase <= P_START;
            endcase
          end
        end
        S_DONE: begin
          data    <= 1'b0;
          playing <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CAS_MONITOR_EN
  always_ff @(posedge clk or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      audio_mon <= '0;
    end else if (!playing) begin
      audio_mon <= '0;
    end else begin
      audio_mon <= data ? MON_AMP : (~MON_AMP + 16'd1);
    end
  end
`else
  // Monitor disabled: output held at zero while MON_AMP stays referenced.
  assign audio_mon = MON_AMP & 16'h0000;
`endif

endmodule

// File: tb/tb_cas_fsk_player.sv
// Directed self-checking bench for cas_fsk_player (HALF_P0=4, HALF_P1=2, RD_LAT=1; second instance with RD_LAT=3).
module tb_cas_fsk_player;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, pause, rewind;
  logic [7:0] tape_len;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] rdata;
  logic       data, playing, eot;
  logic [15:0] audio_mon;

  logic       en3;
  logic [7:0] tape_len3;
  logic [7:0] mem_addr3;
  logic       mem_rd3;
  logic [7:0] p3 [0:2];
  logic       data3, playing3, eot3;
  logic [15:0] audio_mon3;

  logic [7:0] mem [0:255];
  int         rd_pulses = 0;
  int         checks = 0;
  int         failures = 0;
  bit         trace[$];
  int         runs[$];
  int         exp_runs[$];
  int         lead;
  bit         pause_seen;

  always #5 clk = ~clk;

  cas_fsk_player #(.ADDR_W(8), .CNT_W(4), .HALF_P0(4), .HALF_P1(2), .RD_LAT(1), .MON_AMP(16'h1000)) dut (
    .clk(clk), .COCO_RESET_N(rst_n), .en(en), .pause(pause), .rewind(rewind), .tape_len(tape_len),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(rdata), .data(data), .playing(playing), .eot(eot),
    .audio_mon(audio_mon));

  cas_fsk_player #(.ADDR_W(8), .CNT_W(4), .HALF_P0(4), .HALF_P1(2), .RD_LAT(3), .MON_AMP(16'h1000)) dut3 (
    .clk(clk), .COCO_RESET_N(rst_n), .en(en3), .pause(1'b0), .rewind(1'b0), .tape_len(tape_len3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_data(p3[2]), .data(data3), .playing(playing3), .eot(eot3),
    .audio_mon(audio_mon3));

  always @(posedge clk) begin
    if (mem_rd) rdata <= mem[mem_addr];
    if (mem_rd3) p3[0] <= mem[mem_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (mem_rd) rd_pulses <= rd_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; pause = 1'b0; rewind = 1'b0; en3 = 1'b0;
    tape_len = '0; tape_len3 = '0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_runs.push_back(b[i] ? 2 : 4);
      exp_runs.push_back(b[i] ? 2 : 4);
    end
  endtask

  // Plays with en=1 until eot or budget; optional pause window after sample p_at lasting p_len samples.
  task automatic run_trace(input int max_cyc, input int p_at, input int p_len);
    trace.delete();
    pause_seen = 1'b0;
    en = 1'b1;
    for (int t = 0; t < max_cyc; t++) begin
      step();
      if (eot) break;
      trace.push_back(data);
      if (t > p_at && t <= p_at + p_len) pause_seen = pause_seen | playing | data;
      if (t == p_at) pause = 1'b1;
      if (t == p_at + p_len) pause = 1'b0;
    end
  endtask

  task automatic analyze();
    int  len;
    bit  lvl;
    bit  started;
    runs.delete();
    lead = 0; len = 0; lvl = 1'b0; started = 1'b0;
    foreach (trace[i]) begin
      if (!started) begin
        if (trace[i]) begin started = 1'b1; lvl = 1'b1; len = 1; end
        else lead++;
      end else if (trace[i] == lvl) begin
        len++;
      end else begin
        runs.push_back(len);
        lvl = trace[i];
        len = 1;
      end
    end
    if (started) runs.push_back(len);
  endtask

  task automatic cmp_runs(input string tag);
    check({tag, "_nruns"}, runs.size(), exp_runs.size());
    foreach (exp_runs[i])
      check($sformatf("%s_run%0d", tag, i), (i < runs.size()) ? runs[i] : 0, exp_runs[i]);
  endtask

  initial begin
    int base;
    int first;
    bit any;
    logic        d3 [0:63];
    logic [15:0] m3 [0:63];

    // Reset state
    do_reset();
    check("rst_addr", mem_addr, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_data", data, 0);
    check("rst_playing", playing, 0);
    check("rst_eot", eot, 0);
    check("rst_mon", audio_mon, 0);

    // 1: single byte A5
    mem[0] = 8'hA5; tape_len = 8'd1;
    base = rd_pulses;
    run_trace(200, -100, 0);
    check("t1_eot", eot, 1);
    analyze();
    check("t1_latency", lead, 3);
    exp_runs.delete(); push_byte(8'hA5);
    cmp_runs("t1");
    check("t1_rd_pulses", rd_pulses - base, 1);
    check("t1_done_data", data, 0);

    // 2: three bytes, gapless
    do_reset();
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h00; tape_len = 8'd3;
    base = rd_pulses;
    run_trace(400, -100, 0);
    check("t2_eot", eot, 1);
    analyze();
    check("t2_stream_len", trace.size() - lead, 160);
    exp_runs.delete(); push_byte(8'h00); push_byte(8'hFF); push_byte(8'h00);
    cmp_runs("t2");
    check("t2_rd_pulses", rd_pulses - base, 3);

    // 3: pause 10 clks one clock into bit 3 of 0F
    do_reset();
    mem[0] = 8'h0F; tape_len = 8'd1;
    run_trace(300, 15, 10);
    check("t3_eot", eot, 1);
    check("t3_quiet_in_pause", pause_seen, 0);
    analyze();
    check("t3_stream_len", trace.size() - lead, 59);
    exp_runs.delete();
    for (int i = 0; i < 6; i++) exp_runs.push_back(2);
    exp_runs.push_back(1); exp_runs.push_back(10);
    exp_runs.push_back(2); exp_runs.push_back(2);
    for (int i = 0; i < 8; i++) exp_runs.push_back(4);
    cmp_runs("t3");

    // 4: rewind during byte 1 of a 2-byte tape, then replay
    do_reset();
    mem[0] = 8'hFF; mem[1] = 8'h00; tape_len = 8'd2;
    en = 1'b1;
    for (int t = 0; t <= 37; t++) step();
    check("t4_pre_data", data, 1);
    check("t4_pre_addr", mem_addr, 2);
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    check("t4_rw_addr", mem_addr, 0);
    check("t4_rw_eot", eot, 0);
    check("t4_rw_data", data, 0);
    base = rd_pulses;
    run_trace(300, -100, 0);
    check("t4_eot", eot, 1);
    analyze();
    exp_runs.delete(); push_byte(8'hFF); push_byte(8'h00);
    cmp_runs("t4");
    check("t4_rd_pulses", rd_pulses - base, 2);

    // 5: empty tape; later tape_len growth must not resume
    do_reset();
    base = rd_pulses;
    en = 1'b1;
    step();
    check("t5_eot", eot, 1);
    any = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step();
      any = any | data | mem_rd;
    end
    check("t5_quiet", any, 0);
    mem[0] = 8'h55; tape_len = 8'd1;
    for (int t = 0; t < 10; t++) step();
    check("t5_still_eot", eot, 1);
    check("t5_rd_pulses", rd_pulses - base, 0);
    rewind = 1'b1; en = 1'b0;
    step();
    rewind = 1'b0;
    check("t5_rw_eot", eot, 0);

    // 6: RD_LAT=3 latency and audio monitor
    do_reset();
    mem[0] = 8'hA5; tape_len3 = 8'd1;
    en3 = 1'b1;
    for (int t = 0; t < 64; t++) begin
      step();
      d3[t] = data3;
      m3[t] = audio_mon3;
    end
    first = -1;
    for (int t = 63; t >= 0; t--) if (d3[t]) first = t;
    check("t6_latency", first, 5);
    if (first < 0 || first > 55) first = 5;
    check("t6_eot", eot3, 1);
`ifdef CAS_MONITOR_EN
    check("t6_mon_rise", m3[first], 16'h0000);
    check("t6_mon_hi", m3[first + 1], 16'h1000);
    check("t6_mon_lag", m3[first + 2], 16'h1000);
    check("t6_mon_lo", m3[first + 3], 16'hF000);
`else
    any = 1'b0;
    for (int t = 0; t < 64; t++) any = any | (|m3[t]);
    check("t6_mon_off", any, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
